// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, arbiter states and latched request type for the dmem path
package dmem_pkg;
    localparam int DMEM_AW = 32;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
    typedef struct packed {
        logic               we;
        logic [DMEM_AW-1:0] addr;
        logic [2:0]         funct3;
        logic [31:0]        wdata;
    } req_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: two-port valid/ready request bus with per-port one-cycle response pulse
interface dmem_arbiter_if #(parameter int ADDR_W = 32);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_we;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][2:0]        req_funct3;
    logic [1:0][31:0]       req_wdata;
    logic [1:0]             rsp_valid;
    logic                   rsp_err;
    logic [31:0]            rsp_data;
    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_data
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_data
    );
endinterface

// File: rtl/dmem_access_check.sv
// dmem_access_check: flags illegal funct3 or misaligned addresses for RV32 loads/stores
module dmem_access_check
    import dmem_pkg::*;
(
    input  logic       i_we,
    input  logic [1:0] i_addr_lo,
    input  logic [2:0] i_funct3,
    output logic       o_err
);
    logic w_f3_ok, w_align_ok;
    assign w_f3_ok = i_we ? (i_funct3 inside {F3_B, F3_H, F3_W})
                          : (i_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign w_align_ok = (i_funct3[1:0] == 2'd1) ? !i_addr_lo[0] :
                        (i_funct3[1:0] == 2'd2) ? (i_addr_lo == 2'b00) : 1'b1;
    assign o_err = !(w_f3_ok && w_align_ok);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares dmem between two requesters, port 0 priority with a starvation guard for port 1
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int ADDR_W   = DMEM_AW
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     bus,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [2:0]        o_mem_funct3,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    arb_state_t    r_state, w_next;
    req_t          r_req, w_req;
    logic          r_port, r_err, w_err, w_gnt0, w_gnt1, w_fire, w_sel;
    logic [WW-1:0] r_wait;
    logic [31:0]   r_rsp_data;
    assign w_gnt1 = (r_state == IDLE) && bus.req_valid[1] && (!bus.req_valid[0] || r_wait >= WAIT_MAX);
    assign w_gnt0 = (r_state == IDLE) && bus.req_valid[0] && !w_gnt1;
    assign w_fire = w_gnt0 || w_gnt1;
    assign w_sel  = w_gnt1;
    assign w_req  = '{we: bus.req_we[w_sel], addr: DMEM_AW'(bus.req_addr[w_sel]),
                      funct3: bus.req_funct3[w_sel], wdata: bus.req_wdata[w_sel]};
    dmem_access_check u_check (
        .i_we      (w_req.we),
        .i_addr_lo (w_req.addr[1:0]),
        .i_funct3  (w_req.funct3),
        .o_err     (w_err)
    );
    assign o_mem_addr    = ADDR_W'(r_req.addr);
    assign o_mem_funct3  = r_req.funct3;
    assign o_mem_wdata   = r_req.wdata;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.req_ready = {w_gnt1, w_gnt0};
    always_comb begin
        w_next        = r_state;
        bus.rsp_valid = 2'b00;
        bus.rsp_err   = 1'b0;
        o_mem_read    = 1'b0;
        o_mem_write   = 1'b0;
        case (r_state)
            IDLE:    w_next = w_fire ? ACCESS : IDLE;
            ACCESS: begin
                w_next      = RESP;
                o_mem_read  = !r_err && !r_req.we;
                o_mem_write = !r_err && r_req.we;
            end
            RESP: begin
                w_next        = IDLE;
                bus.rsp_valid = {r_port, !r_port};
                bus.rsp_err   = r_err;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req      <= '0;
            r_port     <= 1'b0;
            r_err      <= 1'b0;
            r_wait     <= '0;
            r_rsp_data <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (!bus.req_valid[1] || w_gnt1) ? '0 :
                       (r_wait < WAIT_MAX) ? r_wait + 1'b1 : r_wait;
            if (w_fire) begin
                r_req  <= w_req;
                r_port <= w_sel;
                r_err  <= w_err;
            end
            if (r_state == ACCESS) r_rsp_data <= r_err ? '0 : (i_mem_rdata & {32{!r_req.we}});
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a queue scoreboard checked by a decoupled response monitor
module tb_dmem_arbiter;
    import dmem_pkg::*;
    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_funct3;
    logic [7:0]  mem [1024];
    logic [7:0]  b0, b1, b2, b3;
    exp_t        sb[$];
    int          gnt_log[$];
    int          exp_gnt[5] = '{0, 0, 1, 0, 1};
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errs = 0;
    int          strobes = 0;
    int          s0;

    dmem_arbiter_if #(.ADDR_W(32)) bus ();

    dmem_arbiter #(.MAX_WAIT(4), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .o_mem_read   (mem_read),
        .o_mem_write  (mem_write),
        .o_mem_addr   (mem_addr),
        .o_mem_funct3 (mem_funct3),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 1 KB byte-addressed dmem model: combinational read with RV32 extension, store on posedge
    always_comb begin
        b0 = mem[mem_addr[9:0]];
        b1 = mem[mem_addr[9:0] + 10'd1];
        b2 = mem[mem_addr[9:0] + 10'd2];
        b3 = mem[mem_addr[9:0] + 10'd3];
        case (mem_funct3)
            F3_B:    mem_rdata = {{24{b0[7]}}, b0};
            F3_H:    mem_rdata = {{16{b1[7]}}, b1, b0};
            F3_BU:   mem_rdata = {24'd0, b0};
            F3_HU:   mem_rdata = {16'd0, b1, b0};
            default: mem_rdata = {b3, b2, b1, b0};
        endcase
    end
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[9:0]] <= mem_wdata[7:0];
            if (mem_funct3 != F3_B) mem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
            if (mem_funct3 == F3_W) begin
                mem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
                mem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
        end
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_ready"},    {30'd0, bus.req_ready}, 32'd0);
        check({pfx, "_rspvalid"}, {30'd0, bus.rsp_valid}, 32'd0);
        check({pfx, "_rsperr"},   {31'd0, bus.rsp_err},   32'd0);
        check({pfx, "_rspdata"},  bus.rsp_data,           32'd0);
        check({pfx, "_memread"},  {31'd0, mem_read},      32'd0);
        check({pfx, "_memwrite"}, {31'd0, mem_write},     32'd0);
    endtask

    task automatic issue(input int p, input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, input logic err, input logic [31:0] data, input bit want_rsp);
        int t = 0;
        bus.req_we[p]     = we;
        bus.req_addr[p]   = addr;
        bus.req_funct3[p] = f3;
        bus.req_wdata[p]  = wd;
        bus.req_valid[p]  = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.req_ready[p] && t < 50);
        if (!bus.req_ready[p]) check("grant_timeout", {31'd0, bus.req_ready[p]}, 32'd1);
        else if (want_rsp) sb.push_back('{port: p[0], err: err, data: data, cyc: cyc + 2});
        @(posedge clk);
        #1 bus.req_valid[p] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                strobes += (mem_read || mem_write) ? 1 : 0;
                if (|(bus.req_valid & bus.req_ready)) gnt_log.push_back(bus.req_ready[1] ? 1 : 0);
                if (bus.rsp_valid != 2'b00) begin
                    if (sb.size() == 0) check("unexpected_rsp", {30'd0, bus.rsp_valid}, 32'd0);
                    else begin
                        e = sb.pop_front();
                        check("rsp_port",    {30'd0, bus.rsp_valid}, e.port ? 32'd2 : 32'd1);
                        check("rsp_err",     {31'd0, bus.rsp_err},   {31'd0, e.err});
                        check("rsp_data",    bus.rsp_data,           e.data);
                        check("rsp_latency", cyc,                    e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        bus.req_valid  = '0;
        bus.req_we     = '0;
        bus.req_addr   = '0;
        bus.req_funct3 = '0;
        bus.req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1 check_idle("reset");
        rst = 1'b0;
        // store then load on port 0
        issue(0, 1'b1, 32'h8, F3_W, 32'd10, 1'b0, 32'd0, 1'b1);
        issue(0, 1'b0, 32'h8, F3_W, 32'd0, 1'b0, 32'd10, 1'b1);
        drain();
        // misaligned halfword on port 1 never reaches dmem
        s0 = strobes;
        issue(1, 1'b0, 32'h101, F3_H, 32'd0, 1'b1, 32'd0, 1'b1);
        drain();
        check("misaligned_no_strobe", strobes - s0, 32'd0);
        // byte store merge and sign/zero extension
        issue(0, 1'b1, 32'h10, F3_W,  32'h11223344, 1'b0, 32'd0, 1'b1);
        issue(0, 1'b1, 32'h10, F3_B,  32'h000000AB, 1'b0, 32'd0, 1'b1);
        issue(0, 1'b0, 32'h10, F3_BU, 32'd0, 1'b0, 32'h000000AB, 1'b1);
        issue(0, 1'b0, 32'h10, F3_W,  32'd0, 1'b0, 32'h112233AB, 1'b1);
        issue(0, 1'b1, 32'h14, F3_B,  32'h00000080, 1'b0, 32'd0, 1'b1);
        issue(0, 1'b0, 32'h14, F3_B,  32'd0, 1'b0, 32'hFFFFFF80, 1'b1);
        issue(0, 1'b0, 32'h12, F3_HU, 32'd0, 1'b0, 32'h00001122, 1'b1);
        drain();
        // illegal funct3 and misalignment, then a legal load
        s0 = strobes;
        issue(0, 1'b0, 32'h0,  3'd3, 32'd0,  1'b1, 32'd0, 1'b1);
        issue(0, 1'b1, 32'h0,  3'd4, 32'h55, 1'b1, 32'd0, 1'b1);
        issue(0, 1'b0, 32'h12, F3_W, 32'd0,  1'b1, 32'd0, 1'b1);
        issue(1, 1'b1, 32'h13, F3_H, 32'h77, 1'b1, 32'd0, 1'b1);
        drain();
        check("illegal_no_strobe", strobes - s0, 32'd0);
        issue(0, 1'b0, 32'h10, F3_W, 32'd0, 1'b0, 32'h112233AB, 1'b1);
        drain();
        // both ports held valid: starvation guard forces port 1 in
        gnt_log.delete();
        fork
            begin
                issue(0, 1'b0, 32'h8,  F3_W,  32'd0, 1'b0, 32'd10, 1'b1);
                issue(0, 1'b0, 32'h10, F3_BU, 32'd0, 1'b0, 32'h000000AB, 1'b1);
                issue(0, 1'b0, 32'h10, F3_W,  32'd0, 1'b0, 32'h112233AB, 1'b1);
            end
            begin
                issue(1, 1'b0, 32'h14, F3_W,  32'd0, 1'b0, 32'h00000080, 1'b1);
                issue(1, 1'b0, 32'h14, F3_HU, 32'd0, 1'b0, 32'h00000080, 1'b1);
            end
        join
        drain();
        check("grant_count", gnt_log.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < gnt_log.size()) check($sformatf("grant_%0d", i), gnt_log[i], exp_gnt[i]);
        // reset during ACCESS of a store: no response, store still lands
        issue(0, 1'b1, 32'h20, F3_W, 32'd5, 1'b0, 32'd0, 1'b0);
        check("abort_in_access", {31'd0, mem_write}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 check_idle("abort");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 issue(0, 1'b0, 32'h20, F3_W, 32'd0, 1'b0, 32'd5, 1'b1);
        drain();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
